// File: rtl/data_ram_resp.sv
// Word-organised data memory for the CPU data port: byte-lane writes, one-cycle
// registered reads, a second read-only display port, and a zero-fill after reset.
//
//   state   | meaning
//   INIT    | after reset; zero-filling words (or skipping the fill), requests ignored
//   RUN     | normal service, one read and one write per cycle, terminal until reset
module data_ram_resp #(
  parameter int ADDR_W    = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_addr_err,
  output logic        dm_ready,
  input  logic [31:0] test_addr,
  output logic [31:0] test_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     init_cnt_q, init_cnt_d;
  logic                fill_en;

  logic [31:0]         mem [DEPTH];

  logic [ADDR_W-1:0]   dm_idx, t_idx;
  logic                dm_oor, t_oor;
  logic                run_wr, t_hit;
  logic [31:0]         dm_old, merged;

  logic [ADDR_W-1:0]   mem_idx;
  logic [3:0]          mem_be;
  logic [31:0]         mem_wd;

  // Byte-offset bits are intentionally ignored; lanes come from dm_wen alone.
  logic                unused_addr_lsb;
  assign unused_addr_lsb = ^{dm_addr[1:0], test_addr[1:0]};

  assign dm_idx = dm_addr[ADDR_W+1:2];
  assign dm_oor = |dm_addr[31:ADDR_W+2];
  assign t_idx  = test_addr[ADDR_W+1:2];
  assign t_oor  = |test_addr[31:ADDR_W+2];

  assign run_wr = (state_q == ST_RUN) && (dm_wen != 4'b0000) && !dm_oor;
  assign t_hit  = run_wr && (t_idx == dm_idx);
  assign dm_old = mem[dm_idx];

  always_comb begin
    merged = dm_old;
    for (int i = 0; i < 4; i++) begin
      if (dm_wen[i]) merged[8*i +: 8] = dm_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // The extra counter bit marks "all words filled"; the last fill edge and the
  // move to RUN are separate edges, so the counter never aliases a word index.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    fill_en    = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (!INIT_ZERO || init_cnt_q[ADDR_W]) begin
          state_d = ST_RUN;
        end else begin
          fill_en    = 1'b1;
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN: state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    mem_idx = dm_idx;
    mem_be  = 4'b0000;
    mem_wd  = dm_wdata;
    if (fill_en) begin
      mem_idx = init_cnt_q[ADDR_W-1:0];
      mem_be  = 4'b1111;
      mem_wd  = 32'h0000_0000;
    end else if (run_wr) begin
      mem_be  = dm_wen;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  // Reads are write-first: the merged word is what lands in the array this edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dm_rdata    <= 32'h0000_0000;
      dm_addr_err <= 1'b0;
      test_data   <= 32'h0000_0000;
      dm_ready    <= 1'b0;
    end else begin
      dm_ready <= (state_d == ST_RUN);
      if (state_q == ST_RUN) begin
        dm_rdata    <= dm_oor ? 32'h0000_0000 : merged;
        dm_addr_err <= dm_oor;
        if (t_oor)      test_data <= 32'h0000_0000;
        else if (t_hit) test_data <= merged;
        else            test_data <= mem[t_idx];
      end else begin
        dm_rdata    <= 32'h0000_0000;
        dm_addr_err <= 1'b0;
        test_data   <= 32'h0000_0000;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_resp.sv
// Bench for data_ram_resp: a word-array model checked every cycle, plus directed
// vectors with hand-computed values for the init, lane, write-first and range cases.
module tb_data_ram_resp;

  logic        clk;
  logic        resetn;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_addr_err;
  logic        dm_ready;
  logic [31:0] test_addr;
  logic [31:0] test_data;

  int checks = 0;
  int errors = 0;

  data_ram_resp #(.ADDR_W(8), .INIT_ZERO(1'b1)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .dm_addr     (dm_addr),
    .dm_wen      (dm_wen),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_addr_err (dm_addr_err),
    .dm_ready    (dm_ready),
    .test_addr   (test_addr),
    .test_data   (test_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the memory is 256 words that read as zero once ready; requests count
  // only while ready was high before the edge; ready rises 257 edges after release.
  logic [31:0] model_mem [256];
  int          edges;
  logic [31:0] exp_rdata, exp_test;
  logic        exp_err, exp_ready;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      edges     = 0;
      exp_rdata = 0;
      exp_test  = 0;
      exp_err   = 0;
      exp_ready = 0;
      for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    end else begin
      edges++;
      if (exp_ready) begin
        int          idx, tidx;
        logic        oor, toor;
        logic [31:0] w;
        idx  = int'(dm_addr[9:2]);
        oor  = (dm_addr >= 32'h400);
        tidx = int'(test_addr[9:2]);
        toor = (test_addr >= 32'h400);
        w    = model_mem[idx];
        for (int b = 0; b < 4; b++)
          if (dm_wen[b]) w[8*b +: 8] = dm_wdata[8*b +: 8];
        if (!oor && dm_wen != 0) model_mem[idx] = w;
        exp_rdata = oor ? 32'h0 : w;
        exp_err   = oor;
        exp_test  = toor ? 32'h0 : model_mem[tidx];
      end else begin
        exp_rdata = 0;
        exp_test  = 0;
        exp_err   = 0;
      end
      exp_ready = (edges >= 257);
    end
  end

  always @(negedge clk) begin
    chk("ready_model", {31'h0, dm_ready}, {31'h0, exp_ready});
    chk("rdata_model", dm_rdata, exp_rdata);
    chk("err_model",   {31'h0, dm_addr_err}, {31'h0, exp_err});
    chk("test_model",  test_data, exp_test);
  end

  // Called at a negedge; returns at the next negedge with outputs for this request.
  task automatic cyc(input logic [31:0] a, input logic [3:0] w,
                     input logic [31:0] d, input logic [31:0] t);
    dm_addr   = a;
    dm_wen    = w;
    dm_wdata  = d;
    test_addr = t;
    @(negedge clk);
  endtask

  task automatic wait_ready(input int start, output int n);
    n = start;
    while (!dm_ready && n < 400) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    resetn    = 1'b0;
    dm_addr   = 0;
    dm_wen    = 0;
    dm_wdata  = 0;
    test_addr = 0;
    repeat (3) @(negedge clk);
    chk("reset_rdata", dm_rdata, 32'h0);
    chk("reset_ready", {31'h0, dm_ready}, 32'h0);
    chk("reset_err",   {31'h0, dm_addr_err}, 32'h0);
    chk("reset_test",  test_data, 32'h0);

    resetn = 1'b1;
    wait_ready(0, n);
    chk("init_edges", n, 257);
    @(negedge clk);

    cyc(32'h3FC, 4'h0, 32'h0, 32'h3FC);
    chk("fill_read_3fc", dm_rdata, 32'h0);
    chk("fill_err_3fc", {31'h0, dm_addr_err}, 32'h0);

    cyc(32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
    cyc(32'h10, 4'h0, 32'h0, 32'h10);
    chk("full_word", dm_rdata, 32'hDEADBEEF);
    chk("full_word_test", test_data, 32'hDEADBEEF);

    cyc(32'h10, 4'b0100, 32'h00AA0000, 32'h0);
    cyc(32'h12, 4'h0, 32'h0, 32'h0);
    chk("byte_lane", dm_rdata, 32'hDEAABEEF);

    cyc(32'h20, 4'hF, 32'h11223344, 32'h0);
    cyc(32'h20, 4'b0001, 32'h000000FF, 32'h20);
    chk("rdw_merge", dm_rdata, 32'h112233FF);
    chk("rdw_test_merge", test_data, 32'h112233FF);

    cyc(32'h400, 4'hF, 32'h55555555, 32'h1000);
    chk("oor_err", {31'h0, dm_addr_err}, 32'h1);
    chk("oor_rdata", dm_rdata, 32'h0);
    chk("oor_test", test_data, 32'h0);
    cyc(32'h000, 4'h0, 32'h0, 32'h0);
    chk("oor_word0", dm_rdata, 32'h0);
    chk("oor_err_clear", {31'h0, dm_addr_err}, 32'h0);

    cyc(32'h8000_0010, 4'hF, 32'h12345678, 32'h0);
    cyc(32'h10, 4'h0, 32'h0, 32'h0);
    chk("upper_bit_drop", dm_rdata, 32'hDEAABEEF);

    for (int i = 0; i < 8; i++)
      cyc(32'h80 + 32'(i * 4), 4'(i + 1), 32'h01020304 * 32'(i + 7),
          32'h80 + 32'(((i + 3) % 8) * 4));
    for (int i = 0; i < 8; i++)
      cyc(32'h80 + 32'(i * 4) + 32'(i % 4), 4'h0, 32'hFFFFFFFF,
          32'h80 + 32'((7 - i) * 4));
    // word 0x80 got wen=0001 with 0x01020304*7 = 0x070E151C -> low byte 1C
    cyc(32'h80, 4'h0, 32'h0, 32'h84);
    chk("pattern_w80", dm_rdata, 32'h0000001C);
    // word 0x84 got wen=0010 with 0x01020304*8 = 0x08101820 -> byte1 18
    chk("pattern_w84", test_data, 32'h00001800);

    repeat (100) @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk("midreset_ready", {31'h0, dm_ready}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    cyc(32'h40, 4'hF, 32'hCAFEF00D, 32'h0);
    dm_wen = 4'h0;
    chk("init_req_rdata", dm_rdata, 32'h0);
    chk("init_req_ready", {31'h0, dm_ready}, 32'h0);
    wait_ready(51, n);
    chk("reinit_edges", n, 257);
    @(negedge clk);
    cyc(32'h40, 4'h0, 32'h0, 32'h10);
    chk("init_write_ignored", dm_rdata, 32'h0);
    chk("refill_w10", test_data, 32'h0);
    cyc(32'h0, 4'h0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
